// File: rtl/vid_timing_sched.sv
// Video timing scheduler: sync/blank/active-video generator stepped by gen_ce, with fault-driven blanked resync.
// Build macro VID_TIMING_SCHED_POL_EN adds hsync_pol/vsync_pol inputs (sampled in IDLE) that invert the syncs.
module vid_timing_sched #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int RESYNC_LINES = 4,
    parameter int LOCK_FRAMES  = 3
) (
    input  logic       aclk,
    input  logic       rst,
    input  logic       enable,
    input  logic       gen_ce,
    input  logic       locked,
    input  logic       wr_error,
`ifdef VID_TIMING_SCHED_POL_EN
    input  logic       hsync_pol,
    input  logic       vsync_pol,
`endif
    output logic       vtg_hsync,
    output logic       vtg_vsync,
    output logic       vtg_hblank,
    output logic       vtg_vblank,
    output logic       vtg_act_vid,
    output logic       frame_start,
    output logic       busy,
    output logic       lock_fail,
    output logic [7:0] resync_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int RW = $clog2(RESYNC_LINES + 1);
    localparam int LW = $clog2(LOCK_FRAMES + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [RW-1:0] RL_LAST = RW'(RESYNC_LINES - 1);
    localparam logic [LW-1:0] UF_LAST = LW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, START, RUN, RESYNC} state_t;

    state_t        state, state_nx;
    logic [HW-1:0] h_cnt, h_nx, h_step;
    logic [VW-1:0] v_cnt, v_nx, v_step;
    logic [RW-1:0] rl_cnt, rl_nx;
    logic [LW-1:0] uf_cnt, uf_nx;
    logic          hs_q, vs_q, hb_q, vb_q, av_q, fs_q;
    logic          hs_nx, vs_nx, hb_nx, vb_nx, av_nx, fs_nx;
    logic          lf_nx;
    logic [7:0]    rc_nx;
    logic          locked_q;
    logic          h_last, v_last, fault, lock_to;
    logic          dec_hs, dec_vs, dec_hb, dec_vb;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign h_step = h_last ? '0 : h_cnt + HW'(1);
    assign v_step = h_last ? (v_last ? '0 : v_cnt + VW'(1)) : v_cnt;

    assign dec_hb = (h_cnt >= H_ACT);
    assign dec_hs = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign dec_vb = (v_cnt >= V_ACT);
    assign dec_vs = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // Write error and lock loss coincide as a single fault event.
    assign fault   = wr_error | (locked_q & ~locked);
    assign lock_to = ~locked & gen_ce & h_last & v_last & (uf_cnt == UF_LAST);

    always_comb begin
        state_nx = state;
        h_nx     = h_cnt;
        v_nx     = v_cnt;
        rl_nx    = rl_cnt;
        uf_nx    = uf_cnt;
        hs_nx    = hs_q;
        vs_nx    = vs_q;
        hb_nx    = hb_q;
        vb_nx    = vb_q;
        av_nx    = av_q;
        fs_nx    = 1'b0;
        lf_nx    = lock_fail;
        rc_nx    = resync_count;
        if (!enable) begin
            state_nx = IDLE;
            h_nx     = '0;
            v_nx     = '0;
            rl_nx    = '0;
            uf_nx    = '0;
            hs_nx    = 1'b0;
            vs_nx    = 1'b0;
            hb_nx    = 1'b1;
            vb_nx    = 1'b1;
            av_nx    = 1'b0;
            lf_nx    = 1'b0;
            rc_nx    = '0;
        end else begin
            case (state)
                IDLE: state_nx = START;
                START: begin
                    if (gen_ce) begin
                        hs_nx    = dec_hs;
                        vs_nx    = dec_vs;
                        hb_nx    = dec_hb;
                        vb_nx    = dec_vb;
                        av_nx    = !dec_hb && !dec_vb;
                        fs_nx    = 1'b1;
                        h_nx     = h_step;
                        v_nx     = v_step;
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (locked)
                        uf_nx = '0;
                    else if (gen_ce && h_last && v_last)
                        uf_nx = uf_cnt + LW'(1);
                    // A fault on the frame-wrap step suppresses that frame_start.
                    if (fault || lock_to) begin
                        state_nx = RESYNC;
                        h_nx     = '0;
                        v_nx     = '0;
                        rl_nx    = '0;
                        hs_nx    = 1'b0;
                        vs_nx    = 1'b0;
                        hb_nx    = 1'b1;
                        vb_nx    = 1'b1;
                        av_nx    = 1'b0;
                        if (fault && resync_count != 8'hFF)
                            rc_nx = resync_count + 8'd1;
                        if (lock_to) begin
                            lf_nx = 1'b1;
                            uf_nx = '0;
                        end
                    end else if (gen_ce) begin
                        hs_nx = dec_hs;
                        vs_nx = dec_vs;
                        hb_nx = dec_hb;
                        vb_nx = dec_vb;
                        av_nx = !dec_hb && !dec_vb;
                        fs_nx = (h_cnt == '0) && (v_cnt == '0);
                        h_nx  = h_step;
                        v_nx  = v_step;
                    end
                end
                RESYNC: begin
                    // Only h runs here; v stays 0 so the restart begins at 0,0.
                    if (gen_ce) begin
                        h_nx = h_step;
                        if (h_last) begin
                            if (rl_cnt == RL_LAST) begin
                                rl_nx    = '0;
                                state_nx = START;
                            end else begin
                                rl_nx = rl_cnt + RW'(1);
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            h_cnt        <= '0;
            v_cnt        <= '0;
            rl_cnt       <= '0;
            uf_cnt       <= '0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            hb_q         <= 1'b1;
            vb_q         <= 1'b1;
            av_q         <= 1'b0;
            fs_q         <= 1'b0;
            lock_fail    <= 1'b0;
            resync_count <= '0;
            locked_q     <= 1'b0;
        end else begin
            state        <= state_nx;
            h_cnt        <= h_nx;
            v_cnt        <= v_nx;
            rl_cnt       <= rl_nx;
            uf_cnt       <= uf_nx;
            hs_q         <= hs_nx;
            vs_q         <= vs_nx;
            hb_q         <= hb_nx;
            vb_q         <= vb_nx;
            av_q         <= av_nx;
            fs_q         <= fs_nx;
            lock_fail    <= lf_nx;
            resync_count <= rc_nx;
            locked_q     <= locked;
        end
    end

`ifdef VID_TIMING_SCHED_POL_EN
    logic hpol_q, vpol_q;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            hpol_q <= 1'b0;
            vpol_q <= 1'b0;
        end else if (state == IDLE) begin
            hpol_q <= hsync_pol;
            vpol_q <= vsync_pol;
        end
    end

    // While IDLE (including reset) the live pol inputs set the idle sync level.
    assign vtg_hsync = hs_q ^ ((state == IDLE) ? hsync_pol : hpol_q);
    assign vtg_vsync = vs_q ^ ((state == IDLE) ? vsync_pol : vpol_q);
`else
    assign vtg_hsync = hs_q;
    assign vtg_vsync = vs_q;
`endif

    assign vtg_hblank  = hb_q;
    assign vtg_vblank  = vb_q;
    assign vtg_act_vid = av_q;
    assign frame_start = fs_q;
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_vid_timing_sched.sv
// Directed bench for vid_timing_sched on a tiny 7x5 raster (H 4/1/1/1, V 2/1/1/1).
module tb_vid_timing_sched;
    logic       aclk, rst, enable, gen_ce, locked, wr_error;
    logic       vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank, vtg_act_vid;
    logic       frame_start, busy, lock_fail;
    logic [7:0] resync_count;
`ifdef VID_TIMING_SCHED_POL_EN
    logic       hsync_pol, vsync_pol;
    initial begin
        hsync_pol = 1'b0;
        vsync_pol = 1'b0;
    end
`endif

    int n_cmp = 0;
    int n_err = 0;
    int j, act_n, fs_n, fs_first, fs_gap, found;

    // {hsync, vsync, hblank, vblank, act_vid, frame_start} with everything blanked
    localparam int IDLE_V = 32'b001100;

    vid_timing_sched #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .RESYNC_LINES(4), .LOCK_FRAMES(3)
    ) dut (
        .aclk(aclk),
        .rst(rst),
        .enable(enable),
        .gen_ce(gen_ce),
        .locked(locked),
        .wr_error(wr_error),
`ifdef VID_TIMING_SCHED_POL_EN
        .hsync_pol(hsync_pol),
        .vsync_pol(vsync_pol),
`endif
        .vtg_hsync(vtg_hsync),
        .vtg_vsync(vtg_vsync),
        .vtg_hblank(vtg_hblank),
        .vtg_vblank(vtg_vblank),
        .vtg_act_vid(vtg_act_vid),
        .frame_start(frame_start),
        .busy(busy),
        .lock_fail(lock_fail),
        .resync_count(resync_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int outs();
        return {26'd0, vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank, vtg_act_vid, frame_start};
    endfunction

    // Expected registered outputs for the j-th timing step after a frame restart.
    function automatic int dec(input int jj, input logic fs_en);
        int h, v;
        h = jj % 7;
        v = (jj / 7) % 5;
        return {26'd0, h == 5, v == 3, h >= 4, v >= 2, (h < 4) && (v < 2),
                fs_en && (h == 0) && (v == 0)};
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; gen_ce = 1'b0; locked = 1'b1; wr_error = 1'b0;
        #1;
        check("reset_outs", outs(), IDLE_V);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_lock_fail", {31'd0, lock_fail}, 0);
        check("reset_count", {24'd0, resync_count}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_outs", outs(), IDLE_V);

        enable = 1'b1; gen_ce = 1'b1;
        tick();
        check("start_busy", {31'd0, busy}, 1);
        check("start_outs", outs(), IDLE_V);

        act_n = 0; fs_n = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            check("frame_step", outs(), dec(k, 1'b1));
            if (vtg_act_vid) act_n++;
            if (frame_start) fs_n++;
        end
        check("act_vid_per_2_frames", act_n, 16);
        check("frame_start_per_2_frames", fs_n, 2);

        fs_first = -1; fs_gap = 0;
        for (int c = 0; c < 140; c++) begin
            gen_ce = (c % 2 == 0);
            tick();
            j = 70 + c / 2;
            check("ce_toggle_step", outs(), dec(j, gen_ce));
            if (frame_start) begin
                if (fs_first < 0) fs_first = c;
                else fs_gap = c - fs_first;
            end
        end
        check("ce_toggle_frame_period", fs_gap, 70);
        gen_ce = 1'b1;

        for (int k = 140; k < 149; k++) begin
            tick();
            check("pre_fault_step", outs(), dec(k, 1'b1));
        end
        wr_error = 1'b1;
        tick();
        wr_error = 1'b0;
        check("fault_blank", outs(), IDLE_V);
        check("fault_count", {24'd0, resync_count}, 1);
        check("fault_busy", {31'd0, busy}, 1);
        for (int r = 1; r <= 28; r++) begin
            wr_error = (r == 5);
            tick();
            check("resync_blank", outs(), IDLE_V);
        end
        wr_error = 1'b0;
        check("resync_wr_error_ignored", {24'd0, resync_count}, 1);
        tick();
        check("restart_frame_start", outs(), dec(0, 1'b1));
        for (int k = 1; k <= 35; k++) begin
            tick();
            check("post_resync_step", outs(), dec(k, 1'b1));
        end

        locked = 1'b0;
        tick();
        check("lock_edge_blank", outs(), IDLE_V);
        check("lock_edge_count", {24'd0, resync_count}, 2);
        check("lock_edge_no_fail", {31'd0, lock_fail}, 0);
        for (int r = 0; r < 28; r++) tick();
        check("lock_resync_end_blank", outs(), IDLE_V);
        tick();
        check("lock_restart", outs(), dec(0, 1'b1));
        for (int k = 1; k <= 104; k++) begin
            tick();
            if (k == 35 || k == 70) check("unlocked_wrap_frame_start", {31'd0, frame_start}, 1);
            if (k == 103) check("lock_fail_before_third_wrap", {31'd0, lock_fail}, 0);
        end
        check("lock_fail_set", {31'd0, lock_fail}, 1);
        tick();
        check("lock_fail_resync_blank", outs(), IDLE_V);
        check("lock_fail_busy", {31'd0, busy}, 1);
        check("lock_fail_count", {24'd0, resync_count}, 2);

        enable = 1'b0;
        tick();
        check("disable_lock_fail_clear", {31'd0, lock_fail}, 0);
        check("disable_count_clear", {24'd0, resync_count}, 0);
        check("disable_busy", {31'd0, busy}, 0);
        check("disable_outs", outs(), IDLE_V);

        locked = 1'b1; enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            found = 0;
            for (int w = 0; w < 80 && found == 0; w++) begin
                tick();
                if (frame_start) found = 1;
            end
            check("sat_wait_frame_start", found, 1);
            wr_error = 1'b1;
            tick();
            wr_error = 1'b0;
            if (i == 254) check("sat_reach_255", {24'd0, resync_count}, 255);
        end
        check("sat_hold_255", {24'd0, resync_count}, 255);

        found = 0;
        for (int w = 0; w < 80 && found == 0; w++) begin
            tick();
            if (frame_start) found = 1;
        end
        check("rst_pre_frame_start", found, 1);
        tick();
        check("rst_pre_active", outs(), dec(1, 1'b1));
        rst = 1'b1;
        #1;
        check("rst_async_outs", outs(), IDLE_V);
        check("rst_async_busy", {31'd0, busy}, 0);
        check("rst_async_count", {24'd0, resync_count}, 0);
        tick();
        rst = 1'b0;
        check("rst_held_outs", outs(), IDLE_V);
        tick();
        check("rst_release_start_busy", {31'd0, busy}, 1);
        check("rst_release_start_outs", outs(), IDLE_V);
        tick();
        check("rst_release_frame_start", outs(), dec(0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
